// File: rtl/dmem_arbiter_pkg.sv
// Shared sizes and port-ID encoding for the data-memory arbiter.
// Build option: define DMEM_ARB_RR_EN for round-robin grant, otherwise port A has fixed priority.
`ifndef DMEM_ARBITER_DEFS
`define DMEM_ARBITER_DEFS
`define MEM_SPACE 8
`define DSIZE 16
`define PORT_A 1'b0
`define PORT_B 1'b1
`endif

package dmem_arbiter_pkg;

  typedef enum logic {
    PID_A = `PORT_A,
    PID_B = `PORT_B
  } port_id_t;

  // The port that should win a tie after `last` was granted.
  function automatic port_id_t other_port(input port_id_t last);
    return (last == PID_A) ? PID_B : PID_A;
  endfunction

endpackage

// File: rtl/dmem_arbiter_pick.sv
// Grant selection between port A and port B; combinational grant, one grant per cycle.
// DMEM_ARB_RR_EN: round-robin on contention; undefined: port A always wins.
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic a_valid,
  input  logic b_valid,
  output logic grant_a,
  output logic grant_b
);

`ifdef DMEM_ARB_RR_EN
  // Port preferred on the next contention; moves only when something is granted.
  port_id_t pref;

  always_comb begin
    grant_a = a_valid && (!b_valid || pref == PID_A);
    grant_b = b_valid && !grant_a;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pref <= PID_A;
    end else if (grant_a) begin
      pref <= other_port(PID_A);
    end else if (grant_b) begin
      pref <= other_port(PID_B);
    end
  end
`else
  always_comb begin
    grant_a = a_valid;
    grant_b = b_valid && !a_valid;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter onto one registered-read data memory; accept -> issue -> response, 2-edge latency.
// One transfer per cycle, loser waits with ready low; responses have no backpressure. Option: DMEM_ARB_RR_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = `MEM_SPACE,
  parameter int DATA_W = `DSIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_resp_valid,
  output logic [DATA_W-1:0] a_resp_rdata,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_resp_valid,
  output logic [DATA_W-1:0] b_resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_en,
  input  logic [DATA_W-1:0] mem_data_out
);

  logic grant_a;
  logic grant_b;

  dmem_arb_pick u_pick (
`ifdef DMEM_ARB_RR_EN
    .clk     (clk),
    .rst     (rst),
`endif
    .a_valid (a_req_valid),
    .b_valid (b_req_valid),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign a_req_ready = grant_a && !rst;
  assign b_req_ready = grant_b && !rst;

  logic     accept;
  port_id_t acc_port;
  assign accept   = a_req_ready || b_req_ready;
  assign acc_port = b_req_ready ? PID_B : PID_A;

  // Issue stage: mem_addr / mem_data_in are the stage registers themselves,
  // so they naturally hold their last values while idle.
  logic     iss_vld;
  logic     iss_we;
  port_id_t iss_port;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_vld     <= 1'b0;
      iss_we      <= 1'b0;
      iss_port    <= PID_A;
      mem_addr    <= '0;
      mem_data_in <= '0;
    end else begin
      iss_vld <= accept;
      if (accept) begin
        iss_port    <= acc_port;
        iss_we      <= (acc_port == PID_B) ? b_req_we    : a_req_we;
        mem_addr    <= (acc_port == PID_B) ? b_req_addr  : a_req_addr;
        mem_data_in <= (acc_port == PID_B) ? b_req_wdata : a_req_wdata;
      end
    end
  end

  assign mem_write_en = !(iss_vld && iss_we);

  // Response stage: the memory's registered read data lines up with this stage.
  logic              rsp_vld;
  port_id_t          rsp_port;
  logic [DATA_W-1:0] a_hold;
  logic [DATA_W-1:0] b_hold;

  assign a_resp_valid = rsp_vld && (rsp_port == PID_A);
  assign b_resp_valid = rsp_vld && (rsp_port == PID_B);
  assign a_resp_rdata = a_resp_valid ? mem_data_out : a_hold;
  assign b_resp_rdata = b_resp_valid ? mem_data_out : b_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld  <= 1'b0;
      rsp_port <= PID_A;
      a_hold   <= '0;
      b_hold   <= '0;
    end else begin
      rsp_vld  <= iss_vld;
      rsp_port <= iss_port;
      if (a_resp_valid) begin
        a_hold <= mem_data_out;
      end
      if (b_resp_valid) begin
        b_hold <= mem_data_out;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of grants, memory image and responses.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req_valid = 1'b0, a_req_we = 1'b0;
  logic [7:0]  a_req_addr = '0;
  logic [15:0] a_req_wdata = '0;
  logic        b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [7:0]  b_req_addr = '0;
  logic [15:0] b_req_wdata = '0;
  logic        a_req_ready, b_req_ready, a_resp_valid, b_resp_valid;
  logic [15:0] a_resp_rdata, b_resp_rdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data_in, mem_data_out;
  logic        mem_write_en;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_resp_valid(a_resp_valid), .a_resp_rdata(a_resp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_resp_valid(b_resp_valid), .b_resp_rdata(b_resp_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Registered-read, read-before-write memory attached to the DUT.
  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  always @(posedge clk) begin
    mem_data_out <= mem[mem_addr];
    if (!mem_write_en) mem[mem_addr] <= mem_data_in;
  end

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model.
  typedef struct {int cyc; logic port; logic we; logic [7:0] addr; logic [15:0] wdata;} op_t;
  typedef struct {int cyc; logic port; logic [15:0] rdata;} rsp_t;
  op_t  iss_q[$];
  rsp_t rsp_q[$];
  logic [15:0] hold_a = '0, hold_b = '0, m_wdata = '0;
  logic [7:0]  m_addr = '0;
  logic        pref = 1'b0;       // 0 = A preferred on the next contention
  logic [15:0] a_log[$], b_log[$];
  int          a_cyc[$];
  logic [7:0]  wr_log[$];

  always @(negedge clk) begin : cmp
    op_t  o;
    rsp_t r;
    logic ev_a, ev_b, we_n, ga, gb;
    if (rst) begin
      iss_q.delete(); rsp_q.delete();
      hold_a = '0; hold_b = '0; m_addr = '0; m_wdata = '0; pref = 1'b0;
      chk("rst_a_ready", a_req_ready, 0);
      chk("rst_b_ready", b_req_ready, 0);
      chk("rst_a_resp_valid", a_resp_valid, 0);
      chk("rst_b_resp_valid", b_resp_valid, 0);
      chk("rst_a_rdata", a_resp_rdata, 0);
      chk("rst_b_rdata", b_resp_rdata, 0);
      chk("rst_mem_we_n", mem_write_en, 1);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_data_in", mem_data_in, 0);
    end else begin
      ev_a = 1'b0; ev_b = 1'b0; we_n = 1'b1;
      if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
        r = rsp_q.pop_front();
        if (r.port == 1'b0) begin ev_a = 1'b1; hold_a = r.rdata; end
        else begin ev_b = 1'b1; hold_b = r.rdata; end
      end
      if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
        o = iss_q.pop_front();
        m_addr = o.addr; m_wdata = o.wdata; we_n = !o.we;
        r.cyc = cyc + 1; r.port = o.port; r.rdata = ref_mem[o.addr];
        if (o.we) ref_mem[o.addr] = o.wdata;
        rsp_q.push_back(r);
      end
      chk("a_resp_valid", a_resp_valid, ev_a);
      chk("b_resp_valid", b_resp_valid, ev_b);
      chk("a_resp_rdata", a_resp_rdata, hold_a);
      chk("b_resp_rdata", b_resp_rdata, hold_b);
      chk("mem_write_en", mem_write_en, we_n);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_data_in", mem_data_in, m_wdata);
`ifdef DMEM_ARB_RR_EN
      ga = a_req_valid && (!b_req_valid || !pref);
`else
      ga = a_req_valid;
`endif
      gb = b_req_valid && !ga;
      chk("a_req_ready", a_req_ready, ga);
      chk("b_req_ready", b_req_ready, gb);
      if (ga) begin
        o.cyc = cyc + 1; o.port = 1'b0; o.we = a_req_we; o.addr = a_req_addr; o.wdata = a_req_wdata;
        iss_q.push_back(o); pref = 1'b1;
      end
      if (gb) begin
        o.cyc = cyc + 1; o.port = 1'b1; o.we = b_req_we; o.addr = b_req_addr; o.wdata = b_req_wdata;
        iss_q.push_back(o); pref = 1'b0;
      end
    end
    if (a_resp_valid) begin a_log.push_back(a_resp_rdata); a_cyc.push_back(cyc); end
    if (b_resp_valid) b_log.push_back(b_resp_rdata);
    if (!rst && !mem_write_en) wr_log.push_back(mem_addr);
  end

  task automatic a_op(input logic we, input logic [7:0] addr, input logic [15:0] wd, output int acc);
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd;
    acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      @(negedge clk); if (a_req_ready) acc = cyc;
      @(posedge clk); #1;
    end
    if (acc < 0) chk("a_accept_timeout", 0, 1);
  endtask

  task automatic b_op(input logic we, input logic [7:0] addr, input logic [15:0] wd, output int acc);
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wd;
    acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      @(negedge clk); if (b_req_ready) acc = cyc;
      @(posedge clk); #1;
    end
    if (acc < 0) chk("b_accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, c0, na, nb, nw, nmis;
    logic [15:0] exp35 [8];
    int g [6];
    int exp_g [6];
    logic a_took, b_took;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'hA000 + 16'(i); ref_mem[i] = 16'hA000 + 16'(i);
    end
    // Reset with a request pending: nothing may be granted.
    a_req_valid = 1'b1;
    @(negedge clk);
    chk("reset_ready_literal", a_req_ready, 0);
    chk("reset_we_n_literal", mem_write_en, 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // A write 0x05 <- 0x1234 granted in the first cycle out of reset, then read back.
    c0 = cyc; na = a_log.size(); nw = wr_log.size();
    a_op(1'b1, 8'h05, 16'h1234, acc);
    chk("first_grant_cycle", acc, c0);
    a_op(1'b0, 8'h05, 16'h0000, acc2);
    idle(4);
    chk("rw05_resp_count", a_log.size(), na + 2);
    chk("rw05_write_pre_word", a_log[na], 16'hA005);
    chk("rw05_read_data", a_log[na + 1], 16'h1234);
    chk("rw05_read_latency", a_cyc[na + 1] - acc2, 2);
    chk("rw05_write_cycles", wr_log.size(), nw + 1);
    chk("rw05_write_addr", wr_log[nw], 8'h05);

    // B write 0x0A <- 0xBEEF, A stays silent; A then reads it back.
    na = a_log.size(); nb = b_log.size();
    b_op(1'b1, 8'h0A, 16'hBEEF, acc);
    idle(4);
    chk("b_wr_resp_count", b_log.size(), nb + 1);
    chk("b_wr_pre_word", b_log[nb], 16'hA00A);
    chk("b_wr_no_a_resp", a_log.size(), na);
    a_op(1'b0, 8'h0A, 16'h0000, acc);
    idle(4);
    chk("a_read_0a", a_log[a_log.size() - 1], 16'hBEEF);

    // Back-to-back A reads 0..7: eight consecutive pulses, in order.
    exp35 = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'h1234, 16'hA006, 16'hA007};
    na = a_log.size();
    for (int i = 0; i < 8; i++) begin
      a_op(1'b0, 8'(i), 16'h0000, acc);
      if (i == 0) acc2 = acc;
    end
    idle(4);
    chk("burst_count", a_log.size(), na + 8);
    chk("burst_first_latency", a_cyc[na] - acc2, 2);
    for (int i = 0; i < 8; i++) begin
      chk("burst_data", a_log[na + i], exp35[i]);
      chk("burst_no_bubble", a_cyc[na + i] - a_cyc[na], i);
    end

    // Reset one cycle after accepting an A write to 0x10: it must vanish.
    na = a_log.size(); nw = wr_log.size();
    a_op(1'b1, 8'h10, 16'h5555, acc);
    rst = 1'b1; a_req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_we_n", mem_write_en, 1);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_a_resp_valid", a_resp_valid, 0);
    @(negedge clk);
    chk("midrst_a_resp_valid2", a_resp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0; c0 = cyc;
    a_op(1'b0, 8'h10, 16'h0000, acc);
    chk("midrst_first_grant", acc, c0);
    idle(4);
    chk("midrst_no_write", wr_log.size(), nw);
    chk("midrst_resp_count", a_log.size(), na + 1);
    chk("midrst_read_10", a_log[na], 16'hA010);

    // Contention with both ports valid every cycle, starting from reset.
    rst = 1'b1; repeat (2) @(posedge clk); #1; rst = 1'b0;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'h20;
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 8'h30;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      g[k] = a_req_ready ? 0 : (b_req_ready ? 1 : 2);
      @(posedge clk); #1;
      if (g[k] == 0) a_req_addr = a_req_addr + 8'd1;
      if (g[k] == 1) b_req_addr = b_req_addr + 8'd1;
    end
`ifdef DMEM_ARB_RR_EN
    exp_g = '{0, 1, 0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0, 0, 0};
`endif
    for (int k = 0; k < 6; k++) chk("contention_grant", g[k], exp_g[k]);
    idle(4);

    // Random traffic, losers hold their request, occasional drops.
    for (int c = 0; c < 600; c++) begin
      if (!(a_req_valid && ($urandom % 16) != 0)) begin
        a_req_valid = ($urandom % 10) < 6;
        a_req_we = $urandom % 2; a_req_addr = 8'($urandom % 16); a_req_wdata = 16'($urandom);
      end
      if (!(b_req_valid && ($urandom % 16) != 0)) begin
        b_req_valid = ($urandom % 10) < 5;
        b_req_we = $urandom % 2; b_req_addr = 8'($urandom % 16); b_req_wdata = 16'($urandom);
      end
      @(negedge clk);
      a_took = a_req_valid && a_req_ready;
      b_took = b_req_valid && b_req_ready;
      @(posedge clk); #1;
      if (a_took) a_req_valid = 1'b0;
      if (b_took) b_req_valid = 1'b0;
    end
    idle(5);

    nmis = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nmis++;
    chk("final_mem_image", nmis, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
